parity_frame_rx: RTL and testbench

Serial frame receiver and parity checker that consumes a bit stream produced by the serial parity generator stage.
- Frame format: start bit (0), DATA_W data bits LSB-first, one parity bit, stop bit (1).
- The block deserialises the frame, recomputes running parity with a two-state even/odd tracker, flags parity and framing errors, and presents the word in parallel to downstream logic.

---
 rtl/fsm_pkg.sv | 20 ++
 rtl/parity_frame_rx.sv | 121 ++++++++++++
 tb/tb_parity_frame_rx.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the serial parity frame receiver: FSM state
// encoding and the even/odd parity constants used by the generator side.
package fsm_pkg;

    // Receiver FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] PAR  = 2'd2;
    localparam logic [1:0] STOP = 2'd3;

    // Running-parity values, identical to the transmitter's encoding
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Two-state parity tracker: a 1 on the line flips even <-> odd
    function automatic logic parity_track(input logic cur, input logic bit_in);
        return cur ^ bit_in;
    endfunction

endpackage

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB-first, parity, stop(1).
// Deserialises the word, checks parity and stop bit, and presents the word
// with a one-cycle valid pulse. The word is delivered even when flagged bad.
module parity_frame_rx
    import fsm_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x,
    input  logic              x_vld,
    output logic [DATA_W-1:0] data,
    output logic              data_vld,
    output logic              par_err,
    output logic              frm_err,
    output logic              busy
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Parity value the data+parity bits must accumulate to
    localparam logic             PAR_EXP  = (ODD_PARITY != 0) ? ODD : EVEN;

    logic [1:0]        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [DATA_W-1:0] shreg_q,    shreg_d;
    logic              par_q,      par_d;
    logic              perr_q,     perr_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic              data_vld_q, data_vld_d;
    logic              par_err_q,  par_err_d;
    logic              frm_err_q,  frm_err_d;

    // Next-state logic: everything advances only on a qualified sample
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        perr_d     = perr_q;
        data_d     = data_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        // The completion pulse lasts exactly one cycle, sample or not
        data_vld_d = 1'b0;

        if (x_vld) begin
            case (state_q)
                IDLE: begin
                    // Any sampled 0 is a start bit, including on a line idling low
                    if (!x) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        par_d   = EVEN;
                    end
                end
                DATA: begin
                    shreg_d[cnt_q] = x;
                    par_d          = parity_track(par_q, x);
                    if (cnt_q == CNT_LAST) begin
                        state_d = PAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PAR: begin
                    // 1 means the received parity bit disagrees with the data
                    perr_d  = x ^ par_q ^ PAR_EXP;
                    state_d = STOP;
                end
                STOP: begin
                    // A 0 here is only a framing error, never a new start bit
                    data_d     = shreg_q;
                    data_vld_d = 1'b1;
                    par_err_d  = perr_q;
                    frm_err_d  = ~x;
                    state_d    = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            par_q      <= EVEN;
            perr_q     <= 1'b0;
            data_q     <= '0;
            data_vld_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            data_vld_q <= data_vld_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign data     = data_q;
    assign data_vld = data_vld_q;
    assign par_err  = par_err_q;
    assign frm_err  = frm_err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: an even-parity and an odd-parity
// instance, expected words queued as frames are sent, observed pulses queued
// by a monitor, and the two queues compared after each scenario.
module tb_parity_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       xe, ve, xo, vo;
    logic [7:0] data_e, data_o;
    logic       dv_e, pe_e, fe_e, busy_e;
    logic       dv_o, pe_o, fe_o, busy_o;

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(0)) dut_e (
        .clk(clk), .rst(rst), .x(xe), .x_vld(ve),
        .data(data_e), .data_vld(dv_e), .par_err(pe_e), .frm_err(fe_e), .busy(busy_e)
    );

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1)) dut_o (
        .clk(clk), .rst(rst), .x(xo), .x_vld(vo),
        .data(data_o), .data_vld(dv_o), .par_err(pe_o), .frm_err(fe_o), .busy(busy_o)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int vs_o   = 0;
    int pcyc_e = 0;

    logic [9:0] exp_e[$];
    logic [9:0] obs_e[$];
    logic [9:0] exp_o[$];
    logic [9:0] obs_o[$];
    int         pvs_o[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (vo) vs_o <= vs_o + 1;
    end

    // Record every completion pulse with its word and flags
    always @(negedge clk) begin
        if (dv_e) begin
            obs_e.push_back({data_e, pe_e, fe_e});
            pcyc_e <= cyc;
        end
        if (dv_o) begin
            obs_o.push_back({data_o, pe_o, fe_o});
            pvs_o.push_back(vs_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input int sel, input logic b, input logic v);
        @(negedge clk);
        if (sel == 0) begin xe = b; ve = v; end
        else          begin xo = b; vo = v; end
    endtask

    task automatic idle(input int sel, input int n);
        repeat (n) drv(sel, 1'b1, 1'b1);
    endtask

    // Send one frame; gap_bit/gap_n insert invalid cycles after that data bit,
    // par_gap inserts invalid cycles while the receiver waits for parity.
    task automatic frame(input int sel, input logic [7:0] w, input logic p, input logic stp,
                         input int gap_bit, input int gap_n, input int par_gap,
                         output int start_cyc);
        logic odd;
        logic perr;
        odd  = (sel != 0);
        perr = (^w) ^ p ^ odd;
        if (sel == 0) exp_e.push_back({w, perr, ~stp});
        else          exp_o.push_back({w, perr, ~stp});
        drv(sel, 1'b0, 1'b1);
        start_cyc = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            drv(sel, w[i], 1'b1);
            if (i == gap_bit) repeat (gap_n) drv(sel, 1'b0, 1'b0);
        end
        repeat (par_gap) drv(sel, 1'b0, 1'b0);
        drv(sel, p, 1'b1);
        drv(sel, stp, 1'b1);
    endtask

    task automatic check_sb(input int sel, input string tag);
        logic [9:0] e, o;
        int ne, no;
        @(posedge clk);
        #1;
        if (sel == 0) begin ne = exp_e.size(); no = obs_e.size(); end
        else          begin ne = exp_o.size(); no = obs_o.size(); end
        chk({tag, " pulses"}, no, ne);
        for (int i = 0; i < ne && i < no; i++) begin
            if (sel == 0) begin e = exp_e.pop_front(); o = obs_e.pop_front(); end
            else          begin e = exp_o.pop_front(); o = obs_o.pop_front(); end
            chk({tag, " word/perr/ferr"}, o, e);
        end
        exp_e.delete(); obs_e.delete();
        exp_o.delete(); obs_o.delete();
    endtask

    initial begin
        int st;
        int d;
        rst = 1'b1;
        xe = 1'b1; ve = 1'b0;
        xo = 1'b1; vo = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset data",     data_e, 8'h00);
        chk("reset data_vld", dv_e,   1'b0);
        chk("reset par_err",  pe_e,   1'b0);
        chk("reset frm_err",  fe_e,   1'b0);
        chk("reset busy",     busy_e, 1'b0);
        chk("reset busy odd", busy_o, 1'b0);

        // Test 1: clean 0xA5
        frame(0, 8'hA5, 1'b0, 1'b1, -1, 0, 0, st);
        idle(0, 3);
        check_sb(0, "t1");
        chk("t1 latency", pcyc_e - st, 10);
        chk("t1 busy after", busy_e, 1'b0);

        // Test 2: parity error, then a clean frame clears it
        frame(0, 8'hA5, 1'b1, 1'b1, -1, 0, 0, st);
        idle(0, 2);
        frame(0, 8'h3C, 1'b0, 1'b1, -1, 0, 0, st);
        idle(0, 3);
        check_sb(0, "t2");
        chk("t2 par_err held", pe_e, 1'b0);

        // Test 3: framing error; the stop-bit 0 must not start a frame
        frame(0, 8'hFF, 1'b0, 1'b0, -1, 0, 0, st);
        idle(0, 12);
        check_sb(0, "t3");
        chk("t3 busy", busy_e, 1'b0);
        chk("t3 frm_err held", fe_e, 1'b1);
        chk("t3 data held", data_e, 8'hFF);

        // Test 4: stalls inside the data bits and in parity
        frame(0, 8'hA5, 1'b0, 1'b1, 4, 3, 5, st);
        idle(0, 3);
        check_sb(0, "t4");
        chk("t4 latency", pcyc_e - st, 18);

        // Test 5: reset mid-frame, then a clean 0x00
        drv(0, 1'b0, 1'b1);
        for (int i = 0; i <= 5; i++) drv(0, 1'b1, 1'b1);
        #1;
        chk("t5 busy mid-frame", busy_e, 1'b1);
        @(negedge clk);
        rst = 1'b1; ve = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5 busy after rst", busy_e, 1'b0);
        chk("t5 data after rst", data_e, 8'h00);
        frame(0, 8'h00, 1'b0, 1'b1, -1, 0, 0, st);
        idle(0, 3);
        check_sb(0, "t5");

        // Test 6: odd parity, back-to-back frames
        pvs_o.delete();
        frame(1, 8'h01, 1'b0, 1'b1, -1, 0, 0, st);
        frame(1, 8'h03, 1'b1, 1'b1, -1, 0, 0, st);
        idle(1, 3);
        check_sb(1, "t6");
        chk("t6 pulse count", pvs_o.size(), 2);
        if (pvs_o.size() == 2) begin
            d = pvs_o[1] - pvs_o[0];
            chk("t6 spacing", d, 11);
        end

        // Odd-parity mismatch on the odd instance
        frame(1, 8'h01, 1'b1, 1'b1, -1, 0, 0, st);
        idle(1, 3);
        check_sb(1, "t6b");
        chk("t6b par_err held", pe_o, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
